// File: rtl/cluster_periph_arbiter.sv
// cluster_periph_arbiter: shares the cluster peripheral slave ports among NB_MASTERS requesters.
// Decodes the slave ID from the address, arbitrates per slave (round-robin by default), tracks
// outstanding transactions per slave in an in-order FIFO and routes responses back to the issuer.
// Out-of-range IDs are answered locally with an error response one cycle after the grant.
// Optional macro: CLUSTER_PERIPH_ARB_FIXED_PRIO_EN selects fixed-priority arbitration (lowest index wins).
module cluster_periph_arbiter #(
  parameter int unsigned NB_MASTERS      = 8,
  parameter int unsigned NB_SPERIPHS     = 10,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_LSB          = 10,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NB_MASTERS-1:0]                 mst_req_i,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0]      mst_add_i,
  input  logic [NB_MASTERS-1:0]                 mst_wen_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0]      mst_wdata_i,
  input  logic [NB_MASTERS*DATA_WIDTH/8-1:0]    mst_be_i,
  output logic [NB_MASTERS-1:0]                 mst_gnt_o,
  output logic [NB_MASTERS-1:0]                 mst_r_valid_o,
  output logic [NB_MASTERS*DATA_WIDTH-1:0]      mst_r_rdata_o,
  output logic [NB_MASTERS-1:0]                 mst_r_opc_o,
  output logic [NB_SPERIPHS-1:0]                slv_req_o,
  output logic [NB_SPERIPHS*ADDR_WIDTH-1:0]     slv_add_o,
  output logic [NB_SPERIPHS-1:0]                slv_wen_o,
  output logic [NB_SPERIPHS*DATA_WIDTH-1:0]     slv_wdata_o,
  output logic [NB_SPERIPHS*DATA_WIDTH/8-1:0]   slv_be_o,
  input  logic [NB_SPERIPHS-1:0]                slv_gnt_i,
  input  logic [NB_SPERIPHS-1:0]                slv_r_valid_i,
  input  logic [NB_SPERIPHS*DATA_WIDTH-1:0]     slv_r_rdata_i,
  input  logic [NB_SPERIPHS-1:0]                slv_r_opc_i,
  output logic                                  spurious_rsp_o
);

  localparam int unsigned BW = DATA_WIDTH / 8;
  localparam int unsigned MW = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(32'hBADACCE5);

  logic [ID_WIDTH-1:0]   tgt_id   [NB_MASTERS];
  logic [NB_MASTERS-1:0] in_range, eligible, err_gnt, busy_q, err_q;
  logic [NB_SPERIPHS-1:0] win_found, push, pop, empty, full;
  logic [MW-1:0]         win_idx  [NB_SPERIPHS];
  logic [MW-1:0]         fifo_mem [NB_SPERIPHS][MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr_q [NB_SPERIPHS];
  logic [PW-1:0]         rd_ptr_q [NB_SPERIPHS];
  logic [CW-1:0]         cnt_q    [NB_SPERIPHS];
  logic                  spurious_q;
`ifndef CLUSTER_PERIPH_ARB_FIXED_PRIO_EN
  logic [MW-1:0]         rr_ptr_q [NB_SPERIPHS];
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PW'(1);
  endfunction

  // Address decode and eligibility (requesting, not waiting on a response, not in reset)
  always_comb begin
    for (int unsigned m = 0; m < NB_MASTERS; m++) begin
      tgt_id[m]   = mst_add_i[m*ADDR_WIDTH+ID_LSB +: ID_WIDTH];
      in_range[m] = 32'(tgt_id[m]) < NB_SPERIPHS;
      eligible[m] = mst_req_i[m] & ~busy_q[m] & ~rst_i;
    end
    for (int unsigned s = 0; s < NB_SPERIPHS; s++) begin
      empty[s] = (cnt_q[s] == '0);
      full[s]  = (cnt_q[s] == CW'(MAX_OUTSTANDING));
    end
  end

  // Per-slave winner selection, request forwarding, grants and the local error grant
  always_comb begin
    logic [MW-1:0] mi;
    logic          found;
    mi          = '0;
    found       = 1'b0;
    win_found   = '0;
    push        = '0;
    pop         = '0;
    err_gnt     = '0;
    mst_gnt_o   = '0;
    slv_req_o   = '0;
    slv_add_o   = '0;
    slv_wen_o   = '0;
    slv_wdata_o = '0;
    slv_be_o    = '0;
    for (int unsigned s = 0; s < NB_SPERIPHS; s++) begin
      win_idx[s] = '0;
      found      = 1'b0;
      // a full FIFO still accepts a push when the head pops in the same cycle
      pop[s]     = slv_r_valid_i[s] & ~empty[s];
      for (int unsigned k = 0; k < NB_MASTERS; k++) begin
`ifdef CLUSTER_PERIPH_ARB_FIXED_PRIO_EN
        mi = MW'(k);
`else
        mi = MW'((32'(rr_ptr_q[s]) + k) % NB_MASTERS);
`endif
        if (!found && eligible[mi] && in_range[mi] && (32'(tgt_id[mi]) == s)) begin
          found      = 1'b1;
          win_idx[s] = mi;
        end
      end
      win_found[s] = found;
      slv_req_o[s] = found & (~full[s] | pop[s]);
      push[s]      = slv_req_o[s] & slv_gnt_i[s];
      if (found) begin
        slv_add_o[s*ADDR_WIDTH +: ADDR_WIDTH] = mst_add_i[32'(win_idx[s])*ADDR_WIDTH +: ADDR_WIDTH];
        slv_wen_o[s]                          = mst_wen_i[win_idx[s]];
        slv_wdata_o[s*DATA_WIDTH +: DATA_WIDTH] = mst_wdata_i[32'(win_idx[s])*DATA_WIDTH +: DATA_WIDTH];
        slv_be_o[s*BW +: BW]                  = mst_be_i[32'(win_idx[s])*BW +: BW];
      end
      if (push[s]) mst_gnt_o[win_idx[s]] = 1'b1;
    end
    found = 1'b0;
    for (int unsigned m = 0; m < NB_MASTERS; m++) begin
      if (!found && eligible[m] && !in_range[m]) begin
        found      = 1'b1;
        err_gnt[m] = 1'b1;
      end
    end
    mst_gnt_o = mst_gnt_o | err_gnt;
  end

  // Response routing: registered local errors plus slave responses steered by the FIFO head
  always_comb begin
    logic [MW-1:0] head;
    head          = '0;
    mst_r_valid_o = err_q;
    mst_r_opc_o   = err_q;
    mst_r_rdata_o = '0;
    for (int unsigned m = 0; m < NB_MASTERS; m++) begin
      if (err_q[m]) mst_r_rdata_o[m*DATA_WIDTH +: DATA_WIDTH] = ERR_RDATA;
    end
    for (int unsigned s = 0; s < NB_SPERIPHS; s++) begin
      head = fifo_mem[s][rd_ptr_q[s]];
      if (pop[s]) begin
        mst_r_valid_o[head] = 1'b1;
        mst_r_opc_o[head]   = slv_r_opc_i[s];
        mst_r_rdata_o[32'(head)*DATA_WIDTH +: DATA_WIDTH] = slv_r_rdata_i[s*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Control state: busy flags, error responder, FIFO pointers/counts, arbitration pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q     <= '0;
      err_q      <= '0;
      spurious_q <= 1'b0;
      for (int unsigned s = 0; s < NB_SPERIPHS; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
`ifndef CLUSTER_PERIPH_ARB_FIXED_PRIO_EN
        rr_ptr_q[s] <= '0;
`endif
      end
    end else begin
      busy_q     <= (busy_q | mst_gnt_o) & ~mst_r_valid_o;
      err_q      <= err_gnt;
      spurious_q <= |(slv_r_valid_i & empty);
      for (int unsigned s = 0; s < NB_SPERIPHS; s++) begin
        if (push[s]) wr_ptr_q[s] <= ptr_inc(wr_ptr_q[s]);
        if (pop[s])  rd_ptr_q[s] <= ptr_inc(rd_ptr_q[s]);
        cnt_q[s] <= cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
`ifndef CLUSTER_PERIPH_ARB_FIXED_PRIO_EN
        if (push[s]) rr_ptr_q[s] <= MW'((32'(win_idx[s]) + 1) % NB_MASTERS);
`endif
      end
    end
  end

  // Tracking FIFO storage: index of the master owning each outstanding slave transaction
  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NB_SPERIPHS; s++) begin
      if (push[s]) fifo_mem[s][wr_ptr_q[s]] <= win_idx[s];
    end
  end

  assign spurious_rsp_o = spurious_q;

endmodule

// File: tb/tb_cluster_periph_arbiter.sv
// Testbench for cluster_periph_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (per-slave queues of issuing masters, busy bits, arbitration pointers).
module tb_cluster_periph_arbiter;

  localparam int NM = 8, NS = 10, AW = 32, DW = 32, BW = DW / 8, MAXO = 2, ID_LSB = 10, IDW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NM-1:0]    mst_req, mst_wen, mst_gnt_o, mst_r_valid_o, mst_r_opc_o;
  logic [NM*AW-1:0] mst_add;
  logic [NM*DW-1:0] mst_wdata, mst_r_rdata_o;
  logic [NM*BW-1:0] mst_be;
  logic [NS-1:0]    slv_req_o, slv_wen_o, slv_gnt, slv_rv, slv_opc;
  logic [NS*AW-1:0] slv_add_o;
  logic [NS*DW-1:0] slv_wdata_o, slv_rdata;
  logic [NS*BW-1:0] slv_be_o;
  logic             spurious_rsp_o;

  cluster_periph_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .mst_req_i(mst_req), .mst_add_i(mst_add), .mst_wen_i(mst_wen), .mst_wdata_i(mst_wdata),
    .mst_be_i(mst_be), .mst_gnt_o(mst_gnt_o), .mst_r_valid_o(mst_r_valid_o),
    .mst_r_rdata_o(mst_r_rdata_o), .mst_r_opc_o(mst_r_opc_o),
    .slv_req_o(slv_req_o), .slv_add_o(slv_add_o), .slv_wen_o(slv_wen_o), .slv_wdata_o(slv_wdata_o),
    .slv_be_o(slv_be_o), .slv_gnt_i(slv_gnt), .slv_r_valid_i(slv_rv), .slv_r_rdata_i(slv_rdata),
    .slv_r_opc_i(slv_opc), .spurious_rsp_o(spurious_rsp_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int q [NS][$];
  bit m_busy [NM];
  bit m_err [NM];
  int m_rr [NS];
  bit m_spur;

  // Model predictions for the current cycle
  logic [NM-1:0]    e_gnt, e_rv, e_opc, e_err;
  logic [NM*DW-1:0] e_rdata;
  logic [NS-1:0]    e_req, e_pop;
  int               e_win [NS];
  bit               e_spur;

  function automatic int id_of(int m);
    logic [IDW-1:0] f;
    f = mst_add[m*AW+ID_LSB +: IDW];
    return int'(f);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin q[s].delete(); m_rr[s] = 0; end
    for (int m = 0; m < NM; m++) begin m_busy[m] = 1'b0; m_err[m] = 1'b0; end
    m_spur = 1'b0;
  endtask

  task automatic model_eval();
    bit elig [NM];
    int start, m;
    e_gnt = '0; e_rv = '0; e_opc = '0; e_err = '0; e_rdata = '0; e_req = '0; e_pop = '0; e_spur = 1'b0;
    for (int s = 0; s < NS; s++) e_win[s] = -1;
    if (rst) return;
    for (int i = 0; i < NM; i++) elig[i] = mst_req[i] && !m_busy[i];
    for (int s = 0; s < NS; s++) begin
      e_pop[s] = slv_rv[s] && (q[s].size() > 0);
      if (slv_rv[s] && q[s].size() == 0) e_spur = 1'b1;
`ifdef CLUSTER_PERIPH_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = m_rr[s];
`endif
      for (int k = 0; k < NM; k++) begin
        m = (start + k) % NM;
        if (e_win[s] < 0 && elig[m] && id_of(m) == s) e_win[s] = m;
      end
      if (e_win[s] >= 0 && (q[s].size() < MAXO || e_pop[s])) begin
        e_req[s] = 1'b1;
        if (slv_gnt[s]) e_gnt[e_win[s]] = 1'b1;
      end
      if (e_pop[s]) begin
        m = q[s][0];
        e_rv[m] = 1'b1;
        e_opc[m] = slv_opc[s];
        e_rdata[m*DW +: DW] = slv_rdata[s*DW +: DW];
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (m_err[i]) begin e_rv[i] = 1'b1; e_opc[i] = 1'b1; e_rdata[i*DW +: DW] = 32'hBADACCE5; end
    end
    for (int i = 0; i < NM; i++) begin
      if (e_err == '0 && elig[i] && id_of(i) >= NS) begin e_err[i] = 1'b1; e_gnt[i] = 1'b1; end
    end
  endtask

  task automatic model_commit();
    if (rst) begin model_reset(); return; end
    for (int s = 0; s < NS; s++) begin
      if (e_pop[s]) void'(q[s].pop_front());
      if (e_req[s] && slv_gnt[s]) begin q[s].push_back(e_win[s]); m_rr[s] = (e_win[s] + 1) % NM; end
    end
    for (int i = 0; i < NM; i++) begin
      if (e_rv[i]) m_busy[i] = 1'b0;
      if (e_gnt[i]) m_busy[i] = 1'b1;
      m_err[i] = e_err[i];
    end
    m_spur = e_spur;
  endtask

  task automatic cycle_end();
    model_eval();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    mst_req = '0; mst_add = '0; mst_wen = '0; mst_wdata = '0; mst_be = '0;
    slv_gnt = '0; slv_rv = '0; slv_rdata = '0; slv_opc = '0;
  endtask

  task automatic set_mst(int m, int id, bit wen);
    mst_req[m] = 1'b1;
    mst_add[m*AW +: AW] = (32'(id) << ID_LSB) | 32'($urandom_range(0, 1023)) | (32'($urandom_range(0, 255)) << 16);
    mst_wen[m] = wen;
    mst_wdata[m*DW +: DW] = $urandom;
    mst_be[m*BW +: BW] = BW'($urandom);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_mst(0, 1, 1'b1); set_mst(5, 12, 1'b1);
    slv_gnt = '1; slv_rv = '1;
    model_reset();
    @(negedge clk);
    checks++; if (mst_gnt_o !== '0) begin errors++; $display("FAIL rst_gnt: got %h exp 0", mst_gnt_o); end
    checks++; if (slv_req_o !== '0) begin errors++; $display("FAIL rst_slv_req: got %h exp 0", slv_req_o); end
    checks++; if (mst_r_valid_o !== '0 || mst_r_opc_o !== '0) begin errors++; $display("FAIL rst_rvalid: got %h/%h exp 0", mst_r_valid_o, mst_r_opc_o); end
    checks++; if (mst_r_rdata_o !== '0 || slv_add_o !== '0) begin errors++; $display("FAIL rst_data: rdata/add nonzero"); end
    checks++; if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL rst_spur: got %b exp 0", spurious_rsp_o); end
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    apply_reset();
    set_mst(0, 1, 1'b1);
    slv_gnt[1] = 1'b1;
    #1;
    checks++; if (slv_req_o !== 10'h002) begin errors++; $display("FAIL t1_req: got %h exp 002", slv_req_o); end
    checks++; if (mst_gnt_o !== 8'h01) begin errors++; $display("FAIL t1_gnt: got %h exp 01", mst_gnt_o); end
    checks++; if (slv_add_o[AW +: AW] !== mst_add[AW-1:0] || slv_wen_o[1] !== 1'b1 || slv_be_o[BW +: BW] !== mst_be[BW-1:0])
      begin errors++; $display("FAIL t1_fwd: got %h exp %h", slv_add_o[AW +: AW], mst_add[AW-1:0]); end
    cycle_end();
    clear_inputs();
    slv_rv[1] = 1'b1;
    slv_rdata[DW +: DW] = 32'h1234;
    #1;
    checks++; if (mst_r_valid_o !== 8'h01) begin errors++; $display("FAIL t1_rvalid: got %h exp 01", mst_r_valid_o); end
    checks++; if (mst_r_rdata_o[DW-1:0] !== 32'h1234 || mst_r_opc_o !== 8'h00)
      begin errors++; $display("FAIL t1_rdata: got %h/%h exp 1234/00", mst_r_rdata_o[DW-1:0], mst_r_opc_o); end
    cycle_end();
  endtask

  task automatic test_rr_order();
    int exp_w, prev;
    logic [NM-1:0] ev;
    apply_reset();
    prev = 0;
    for (int c = 0; c < 8; c++) begin
      clear_inputs();
      for (int m = 0; m < 4; m++) set_mst(m, 2, 1'b1);
      slv_gnt[2] = 1'b1;
      if (c > 0) begin slv_rv[2] = 1'b1; slv_rdata[2*DW +: DW] = 32'hA000 + 32'(c); end
      #1;
`ifdef CLUSTER_PERIPH_ARB_FIXED_PRIO_EN
      exp_w = c % 2;
`else
      exp_w = c % 4;
`endif
      ev = '0; ev[exp_w] = 1'b1;
      checks++; if (mst_gnt_o !== ev) begin errors++; $display("FAIL rr_gnt c=%0d: got %h exp %h", c, mst_gnt_o, ev); end
      ev = '0; if (c > 0) ev[prev] = 1'b1;
      checks++; if (mst_r_valid_o !== ev) begin errors++; $display("FAIL rr_rvalid c=%0d: got %h exp %h", c, mst_r_valid_o, ev); end
      if (c > 0) begin
        checks++; if (mst_r_rdata_o[prev*DW +: DW] !== 32'hA000 + 32'(c))
          begin errors++; $display("FAIL rr_rdata c=%0d: got %h exp %h", c, mst_r_rdata_o[prev*DW +: DW], 32'hA000 + 32'(c)); end
      end
      prev = exp_w;
      cycle_end();
    end
  endtask

  task automatic test_fifo_full();
    logic [NM-1:0] eg [5] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h04};
    logic [NM-1:0] er [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    bit            eq [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      clear_inputs();
      for (int m = 0; m < 3; m++) set_mst(m, 6, 1'b1);
      slv_gnt[6] = 1'b1;
      slv_rv[6] = (c == 4);
      slv_rdata[6*DW +: DW] = 32'h600D;
      #1;
      checks++; if (mst_gnt_o !== eg[c]) begin errors++; $display("FAIL full_gnt c=%0d: got %h exp %h", c, mst_gnt_o, eg[c]); end
      checks++; if (slv_req_o[6] !== eq[c]) begin errors++; $display("FAIL full_req c=%0d: got %b exp %b", c, slv_req_o[6], eq[c]); end
      checks++; if (mst_r_valid_o !== er[c]) begin errors++; $display("FAIL full_rvalid c=%0d: got %h exp %h", c, mst_r_valid_o, er[c]); end
      cycle_end();
    end
  endtask

  task automatic test_error();
    apply_reset();
    set_mst(3, 12, 1'b1); set_mst(5, 12, 1'b0);
    #1;
    checks++; if (mst_gnt_o !== 8'h08 || slv_req_o !== '0) begin errors++; $display("FAIL err_gnt0: got %h/%h exp 08/000", mst_gnt_o, slv_req_o); end
    cycle_end();
    mst_req[3] = 1'b0;
    #1;
    checks++; if (mst_gnt_o !== 8'h20) begin errors++; $display("FAIL err_gnt1: got %h exp 20", mst_gnt_o); end
    checks++; if (mst_r_valid_o !== 8'h08 || mst_r_opc_o !== 8'h08 || mst_r_rdata_o[3*DW +: DW] !== 32'hBADACCE5)
      begin errors++; $display("FAIL err_rsp3: got %h/%h/%h", mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o[3*DW +: DW]); end
    cycle_end();
    clear_inputs();
    #1;
    checks++; if (mst_r_valid_o !== 8'h20 || mst_r_opc_o !== 8'h20 || mst_r_rdata_o[5*DW +: DW] !== 32'hBADACCE5)
      begin errors++; $display("FAIL err_rsp5: got %h/%h/%h", mst_r_valid_o, mst_r_opc_o, mst_r_rdata_o[5*DW +: DW]); end
    checks++; if (mst_gnt_o !== '0 || slv_req_o !== '0) begin errors++; $display("FAIL err_idle: got %h/%h exp 0", mst_gnt_o, slv_req_o); end
    cycle_end();
  endtask

  task automatic test_spurious();
    apply_reset();
    slv_rv[9] = 1'b1;
    slv_rdata[9*DW +: DW] = 32'hDEAD;
    #1;
    checks++; if (mst_r_valid_o !== '0 || spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL spur_c0: got %h/%b exp 0/0", mst_r_valid_o, spurious_rsp_o); end
    cycle_end();
    clear_inputs();
    #1;
    checks++; if (spurious_rsp_o !== 1'b1 || mst_r_valid_o !== '0) begin errors++; $display("FAIL spur_c1: got %b/%h exp 1/0", spurious_rsp_o, mst_r_valid_o); end
    cycle_end();
    #1;
    checks++; if (spurious_rsp_o !== 1'b0) begin errors++; $display("FAIL spur_c2: got %b exp 0", spurious_rsp_o); end
    cycle_end();
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    set_mst(0, 1, 1'b1); set_mst(1, 4, 1'b0);
    slv_gnt[1] = 1'b1; slv_gnt[4] = 1'b1;
    #1;
    checks++; if (mst_gnt_o !== 8'h03) begin errors++; $display("FAIL mrst_gnt: got %h exp 03", mst_gnt_o); end
    cycle_end();
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (mst_gnt_o !== '0 || slv_req_o !== '0 || mst_r_valid_o !== '0 || spurious_rsp_o !== 1'b0)
      begin errors++; $display("FAIL mrst_out: got %h/%h/%h/%b exp 0", mst_gnt_o, slv_req_o, mst_r_valid_o, spurious_rsp_o); end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    slv_rv[1] = 1'b1; slv_rv[4] = 1'b1;
    #1;
    checks++; if (mst_r_valid_o !== '0) begin errors++; $display("FAIL mrst_late: got %h exp 0", mst_r_valid_o); end
    cycle_end();
    clear_inputs();
    #1;
    checks++; if (spurious_rsp_o !== 1'b1 || mst_r_valid_o !== '0) begin errors++; $display("FAIL mrst_spur: got %b/%h exp 1/0", spurious_rsp_o, mst_r_valid_o); end
    cycle_end();
  endtask

  task automatic test_random(int n);
    int ids [7] = '{0, 1, 2, 6, 9, 12, 15};
    int w;
    apply_reset();
    for (int c = 0; c < n; c++) begin
      clear_inputs();
      for (int m = 0; m < NM; m++) if ($urandom_range(0, 1) == 1) set_mst(m, ids[$urandom_range(0, 6)], 1'($urandom_range(0, 1)));
      for (int s = 0; s < NS; s++) begin
        slv_gnt[s] = ($urandom_range(0, 3) != 0);
        slv_rv[s] = (q[s].size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 39) == 0);
        slv_rdata[s*DW +: DW] = $urandom;
        slv_opc[s] = ($urandom_range(0, 7) == 0);
      end
      #1;
      model_eval();
      checks++; if (mst_gnt_o !== e_gnt) begin errors++; $display("FAIL rnd_gnt c=%0d: got %h exp %h", c, mst_gnt_o, e_gnt); end
      checks++; if (slv_req_o !== e_req) begin errors++; $display("FAIL rnd_req c=%0d: got %h exp %h", c, slv_req_o, e_req); end
      checks++; if (mst_r_valid_o !== e_rv || mst_r_opc_o !== e_opc)
        begin errors++; $display("FAIL rnd_rsp c=%0d: got %h/%h exp %h/%h", c, mst_r_valid_o, mst_r_opc_o, e_rv, e_opc); end
      checks++; if (mst_r_rdata_o !== e_rdata) begin errors++; $display("FAIL rnd_rdata c=%0d: got %h exp %h", c, mst_r_rdata_o, e_rdata); end
      checks++; if (spurious_rsp_o !== m_spur) begin errors++; $display("FAIL rnd_spur c=%0d: got %b exp %b", c, spurious_rsp_o, m_spur); end
      for (int s = 0; s < NS; s++) begin
        if (e_req[s]) begin
          w = e_win[s];
          checks++;
          if ({slv_add_o[s*AW +: AW], slv_wen_o[s], slv_wdata_o[s*DW +: DW], slv_be_o[s*BW +: BW]} !==
              {mst_add[w*AW +: AW], mst_wen[w], mst_wdata[w*DW +: DW], mst_be[w*BW +: BW]})
            begin errors++; $display("FAIL rnd_fwd c=%0d s=%0d: got %h exp %h", c, s, slv_add_o[s*AW +: AW], mst_add[w*AW +: AW]); end
        end
      end
      cycle_end();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_rr_order();
    test_fifo_full();
    test_error();
    test_spurious();
    test_reset_midflight();
    test_random(2000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
